// File: rtl/riscv_core_pkg.sv
// Shared types for the single-cycle RV32I core: widths, opcode map, ALU and
// load/store size encodings.
package rvcpu;

  localparam int Width = 32;

  typedef logic [Width-1:0] addr_t;
  typedef logic [Width-1:0] data_t;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2
  } ls_size_e;

  localparam data_t WfiInsn = 32'h1050_0073;

  // alt selects SUB/SRA; the caller only raises it where funct7[5] is meaningful.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_regfile.sv
// 31-entry register file, two combinational read ports and one write port;
// x0 reads as zero and is never stored.
module regfile
  import rvcpu::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  output data_t      rs1_data,
  output data_t      rs2_data,
  input  logic       we,
  input  logic [4:0] rd_addr,
  input  data_t      rd_data
);

  data_t regs [1:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && (rd_addr != 5'd0)) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/riscv_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and write-back all
// happen in the cycle the instruction is presented on imem_data.
module riscv_core
  import rvcpu::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       irq,
  output addr_t      imem_addr,
  input  data_t      imem_data,
  output logic       imem_valid,
  output addr_t      mem_addr,
  output data_t      mem_w_data,
  input  data_t      mem_r_data,
  output logic [3:0] mem_w_mask,
  output logic       mem_re,
  output logic       mem_we,
  output logic       exception,
  output logic       wfi
);

  addr_t pc;
  logic  exc_q;
  logic  active;

  opcode_e    opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd, rs1, rs2;
  data_t      imm_i, imm_s, imm_b, imm_u, imm_j;
  data_t      rs1_val, rs2_val, wb_data;
  logic       rf_we;

  assign opc   = opcode_e'(imem_data[6:0]);
  assign f3    = imem_data[14:12];
  assign f7    = imem_data[31:25];
  assign rd    = imem_data[11:7];
  assign rs1   = imem_data[19:15];
  assign rs2   = imem_data[24:20];
  assign imm_i = {{20{imem_data[31]}}, imem_data[31:20]};
  assign imm_s = {{20{imem_data[31]}}, imem_data[31:25], imem_data[11:7]};
  assign imm_b = {{19{imem_data[31]}}, imem_data[31], imem_data[7],
                  imem_data[30:25], imem_data[11:8], 1'b0};
  assign imm_u = {imem_data[31:12], 12'b0};
  assign imm_j = {{11{imem_data[31]}}, imem_data[31], imem_data[19:12],
                  imem_data[20], imem_data[30:21], 1'b0};

  regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .we       (rf_we),
    .rd_addr  (rd),
    .rd_data  (wb_data)
  );

  logic     is_load, is_store, is_branch, is_jal, is_jalr, is_wfi, wb_en, illegal;
  alu_op_e  alu_op;
  ls_size_e ls_size;

  always_comb begin
    is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0; is_jal = 1'b0;
    is_jalr = 1'b0; is_wfi   = 1'b0; wb_en     = 1'b0; illegal = 1'b0;
    alu_op  = alu_decode(f3, ((opc == OP_OP) || (f3 == 3'b101)) && f7[5]);
    case (f3[1:0])
      2'b00:   ls_size = LS_B;
      2'b01:   ls_size = LS_H;
      default: ls_size = LS_W;
    endcase
    case (opc)
      OP_LUI, OP_AUIPC: wb_en = 1'b1;
      OP_JAL:    begin is_jal = 1'b1; wb_en = 1'b1; end
      OP_JALR:   begin is_jalr = 1'b1; wb_en = 1'b1; illegal = (f3 != 3'b000); end
      OP_BRANCH: begin is_branch = 1'b1; illegal = (f3[2:1] == 2'b01); end
      OP_LOAD:   begin
        is_load = 1'b1; wb_en = 1'b1;
        illegal = (f3[1:0] == 2'b11) || (f3[2] && f3[1]);
      end
      OP_STORE:  begin is_store = 1'b1; illegal = f3[2] || (f3[1:0] == 2'b11); end
      OP_IMM:    begin
        wb_en = 1'b1;
        if (f3 == 3'b001) illegal = (f7 != 7'h00);
        else if (f3 == 3'b101) illegal = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OP_OP:     begin
        wb_en   = 1'b1;
        illegal = (f7 != 7'h00) && !((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OP_FENCE:  ;
      // WFI is the only SYSTEM encoding implemented; ECALL/EBREAK fault.
      OP_SYSTEM: begin is_wfi = (imem_data == WfiInsn); illegal = (imem_data != WfiInsn); end
      default:   illegal = 1'b1;
    endcase
  end

  data_t      alu_b, alu_res;
  logic [4:0] shamt;

  assign alu_b = (opc == OP_OP) ? rs2_val : imm_i;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = rs1_val + alu_b;
      ALU_SUB:  alu_res = rs1_val - alu_b;
      ALU_SLL:  alu_res = rs1_val << shamt;
      ALU_SLT:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'b0, rs1_val < alu_b};
      ALU_XOR:  alu_res = rs1_val ^ alu_b;
      ALU_SRL:  alu_res = rs1_val >> shamt;
      ALU_SRA:  alu_res = $signed(rs1_val) >>> shamt;
      ALU_OR:   alu_res = rs1_val | alu_b;
      ALU_AND:  alu_res = rs1_val & alu_b;
      default:  alu_res = '0;
    endcase
  end

  logic  br_taken, redirect;
  addr_t pc_plus4, next_pc;

  always_comb begin
    case (f3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign redirect = is_jal || is_jalr || (is_branch && br_taken);

  always_comb begin
    next_pc = pc_plus4;
    if (is_jal)                     next_pc = pc + imm_j;
    else if (is_jalr)               next_pc = (rs1_val + imm_i) & ~32'd1;
    else if (is_branch && br_taken) next_pc = pc + imm_b;
  end

  addr_t      ea;
  logic       mis_ls, fault;
  data_t      byte_lane, load_val, store_data;
  logic [15:0] half_lane;
  logic [3:0] store_mask;

  assign ea     = rs1_val + (is_store ? imm_s : imm_i);
  assign mis_ls = (is_load || is_store) &&
                  (((ls_size == LS_H) && ea[0]) || ((ls_size == LS_W) && (ea[1:0] != 2'b00)));
  assign fault  = illegal || mis_ls || (redirect && next_pc[1]);

  assign byte_lane = mem_r_data >> {ea[1:0], 3'b000};
  assign half_lane = ea[1] ? mem_r_data[31:16] : mem_r_data[15:0];

  always_comb begin
    case (f3)
      3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane[7:0]};
      3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_val = {24'b0, byte_lane[7:0]};
      3'b101:  load_val = {16'b0, half_lane};
      default: load_val = mem_r_data;
    endcase
    case (ls_size)
      LS_B:    begin store_data = {4{rs2_val[7:0]}};  store_mask = 4'b0001 << ea[1:0]; end
      LS_H:    begin store_data = {2{rs2_val[15:0]}}; store_mask = ea[1] ? 4'b1100 : 4'b0011; end
      default: begin store_data = rs2_val;            store_mask = 4'b1111; end
    endcase
  end

  always_comb begin
    case (opc)
      OP_LUI:          wb_data = imm_u;
      OP_AUIPC:        wb_data = pc + imm_u;
      OP_JAL, OP_JALR: wb_data = pc_plus4;
      OP_LOAD:         wb_data = load_val;
      default:         wb_data = alu_res;
    endcase
  end

  assign active     = !rst && !exc_q;
  assign rf_we      = active && wb_en && !fault;
  assign imem_addr  = pc;
  assign imem_valid = active;
  assign exception  = exc_q;
  assign wfi        = active && is_wfi && !irq;
  assign mem_addr   = {ea[31:2], 2'b00};
  assign mem_w_data = store_data;
  assign mem_re     = active && is_load && !fault;
  assign mem_we     = active && is_store && !fault;
  assign mem_w_mask = mem_we ? store_mask : 4'b0000;

  // A fault freezes the PC and latches the flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      exc_q <= 1'b0;
    end else if (active) begin
      if (fault)     exc_q <= 1'b1;
      else if (!wfi) pc    <= next_pc;
    end
  end

endmodule

// File: tb/tb_riscv_core.sv
// Directed bench for riscv_core: small hand-assembled programs run from a
// bench-side instruction/data memory, outputs checked at the falling edge.
module tb_riscv_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq = 1'b0;
  logic [31:0] imem_addr, imem_data, mem_addr, mem_w_data, mem_r_data;
  logic        imem_valid, mem_re, mem_we, exception, wfi;
  logic [3:0]  mem_w_mask;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:127];

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] Nop = 32'h0000_0013;

  riscv_core dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data),
    .mem_w_mask (mem_w_mask),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .exception  (exception),
    .wfi        (wfi)
  );

  always #5 clk = ~clk;

  assign imem_data  = imem[imem_addr[7:2]];
  assign mem_r_data = dmem[mem_addr[8:2]];

  // Store lands mid-cycle so the next instruction's load sees it.
  always @(negedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_w_mask[b]) dmem[mem_addr[8:2]][8*b +: 8] <= mem_w_data[8*b +: 8];
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = Nop;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_pc", imem_addr, 32'h0);
    chk("rst_imem_valid", {31'b0, imem_valid}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_re", {31'b0, mem_re}, 32'h0);
    chk("rst_exception", {31'b0, exception}, 32'h0);
    chk("rst_wfi", {31'b0, wfi}, 32'h0);
    rst = 1'b0;
    #1;
    chk("first_fetch_valid", {31'b0, imem_valid}, 32'h1);
  endtask

  task automatic expect_store(input string tag, input logic [31:0] addr,
                              input logic [3:0] mask, input logic [31:0] data);
    chk({tag, "_we"}, {31'b0, mem_we}, 32'h1);
    chk({tag, "_mask"}, {28'b0, mem_w_mask}, {28'b0, mask});
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_data"}, mem_w_data, data);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) dmem[i] = '0;

    // ALU sequence; results exposed through SW
    clear_imem();
    imem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);          // addi x1,x0,5
    imem[1]  = enc_i(12'hffd, 5'd1, 3'b000, 5'd2, 7'h13);        // addi x2,x1,-3
    imem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);           // add x3,x1,x2
    imem[3]  = enc_s(12'd0, 5'd2, 5'd0, 3'b010);                 // sw x2,0(x0)
    imem[4]  = enc_s(12'd4, 5'd3, 5'd0, 3'b010);                 // sw x3,4(x0)
    imem[5]  = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd4);           // sub x4,x2,x1
    imem[6]  = enc_s(12'd8, 5'd4, 5'd0, 3'b010);                 // sw x4,8(x0)
    imem[7]  = enc_r(7'h00, 5'd1, 5'd4, 3'b010, 5'd5);           // slt x5,x4,x1
    imem[8]  = enc_s(12'd12, 5'd5, 5'd0, 3'b010);
    imem[9]  = enc_r(7'h00, 5'd1, 5'd4, 3'b011, 5'd6);           // sltu x6,x4,x1
    imem[10] = enc_s(12'd16, 5'd6, 5'd0, 3'b010);
    imem[11] = enc_i(12'h401, 5'd4, 3'b101, 5'd7, 7'h13);        // srai x7,x4,1
    imem[12] = enc_s(12'd20, 5'd7, 5'd0, 3'b010);
    imem[13] = enc_i(12'd33, 5'd0, 3'b000, 5'd9, 7'h13);         // addi x9,x0,33
    imem[14] = enc_r(7'h00, 5'd9, 5'd1, 3'b001, 5'd8);           // sll x8,x1,x9
    imem[15] = enc_s(12'd24, 5'd8, 5'd0, 3'b010);
    do_reset();
    chk("addi_no_mem", {27'b0, mem_we, mem_w_mask}, 32'h0);
    step(3);
    chk("pc_after_3", imem_addr, 32'h0000_000c);
    expect_store("x2", 32'h0, 4'b1111, 32'h2);
    step(1); expect_store("x3", 32'h4, 4'b1111, 32'h7);
    step(1); chk("sub_no_mem", {27'b0, mem_we, mem_w_mask}, 32'h0);
    step(1); chk("sub_val", mem_w_data, 32'hffff_fffd);
    step(2); chk("slt_val", mem_w_data, 32'h1);
    step(2); chk("sltu_val", mem_w_data, 32'h0);
    step(2); chk("srai_val", mem_w_data, 32'hffff_fffe);
    step(3); chk("sll_low5_val", mem_w_data, 32'h0000_000a);

    // Loads and stores around 0x100
    clear_imem();
    imem[0]  = {20'hdeadc, 5'd1, 7'h37};                         // lui x1,0xdeadc
    imem[1]  = enc_i(12'heef, 5'd1, 3'b000, 5'd1, 7'h13);        // addi x1,x1,-273
    imem[2]  = enc_i(12'h100, 5'd0, 3'b000, 5'd5, 7'h13);        // addi x5,x0,256
    imem[3]  = enc_s(12'd0, 5'd1, 5'd5, 3'b010);                 // sw x1,0(x5)
    imem[4]  = enc_i(12'd1, 5'd5, 3'b000, 5'd2, 7'h03);          // lb x2,1(x5)
    imem[5]  = enc_i(12'd1, 5'd5, 3'b100, 5'd3, 7'h03);          // lbu x3,1(x5)
    imem[6]  = enc_s(12'd4, 5'd2, 5'd5, 3'b010);
    imem[7]  = enc_s(12'd8, 5'd3, 5'd5, 3'b010);
    imem[8]  = enc_s(12'd2, 5'd1, 5'd5, 3'b000);                 // sb x1,2(x5)
    imem[9]  = enc_s(12'd2, 5'd1, 5'd5, 3'b001);                 // sh x1,2(x5)
    imem[10] = enc_i(12'd2, 5'd5, 3'b001, 5'd4, 7'h03);          // lh x4,2(x5)
    imem[11] = enc_i(12'd2, 5'd5, 3'b101, 5'd6, 7'h03);          // lhu x6,2(x5)
    imem[12] = enc_s(12'd12, 5'd4, 5'd5, 3'b010);
    imem[13] = enc_s(12'd16, 5'd6, 5'd5, 3'b010);
    do_reset();
    step(3); expect_store("sw", 32'h100, 4'b1111, 32'hdead_beef);
    step(1);
    chk("lb_re", {31'b0, mem_re}, 32'h1);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_no_we", {31'b0, mem_we}, 32'h0);
    step(2); expect_store("lb_val", 32'h104, 4'b1111, 32'hffff_ffbe);
    step(1); expect_store("lbu_val", 32'h108, 4'b1111, 32'h0000_00be);
    step(1); expect_store("sb", 32'h100, 4'b0100, 32'hefef_efef);
    step(1); expect_store("sh", 32'h100, 4'b1100, 32'hbeef_beef);
    step(3); chk("lh_val", mem_w_data, 32'hffff_beef);
    step(1); chk("lhu_val", mem_w_data, 32'h0000_beef);

    // Taken branch
    clear_imem();
    imem[4] = enc_b(13'h1ff8, 5'd0, 5'd0, 3'b000);               // beq x0,x0,-8
    do_reset();
    step(4); chk("beq_pc", imem_addr, 32'h10);
    step(1); chk("beq_target", imem_addr, 32'h08);

    // Not-taken branch, JAL, JALR with bit 0 of the target cleared
    clear_imem();
    imem[4]  = enc_b(13'h1ff8, 5'd0, 5'd0, 3'b001);              // bne x0,x0,-8
    imem[8]  = enc_j(21'd16, 5'd1);                              // jal x1,+16
    imem[12] = enc_s(12'd0, 5'd1, 5'd0, 3'b010);                 // sw x1,0(x0)
    imem[13] = enc_i(12'd1, 5'd1, 3'b000, 5'd0, 7'h67);          // jalr x0,1(x1)
    do_reset();
    step(5); chk("bne_fallthrough", imem_addr, 32'h14);
    step(3); chk("jal_pc", imem_addr, 32'h20);
    step(1); chk("jal_target", imem_addr, 32'h30);
    chk("jal_link", mem_w_data, 32'h24);
    step(2); chk("jalr_target", imem_addr, 32'h24);

    // WFI stall, wake by irq, irq ignored elsewhere
    clear_imem();
    imem[4] = 32'h1050_0073;
    do_reset();
    step(4);
    chk("wfi_enter", {31'b0, wfi}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("wfi_hold_pc", imem_addr, 32'h10);
      chk("wfi_hold_flag", {31'b0, wfi}, 32'h1);
    end
    irq = 1'b1;
    #1 chk("wfi_irq_clear", {31'b0, wfi}, 32'h0);
    step(1); chk("wfi_wake_pc", imem_addr, 32'h14);
    step(1); chk("irq_no_effect", imem_addr, 32'h18);
    irq = 1'b0;

    // Reset during a WFI stall
    do_reset();
    step(4);
    chk("wfi_again", {31'b0, wfi}, 32'h1);
    rst = 1'b1;
    step(1);
    chk("rst_in_wfi_pc", imem_addr, 32'h0);
    chk("rst_in_wfi_flag", {31'b0, wfi}, 32'h0);

    // Undefined instruction at 0x04
    clear_imem();
    imem[1] = 32'h0000_0000;
    do_reset();
    step(1);
    chk("illegal_pre_exc", {31'b0, exception}, 32'h0);
    chk("illegal_no_we", {31'b0, mem_we}, 32'h0);
    step(1);
    chk("illegal_exc", {31'b0, exception}, 32'h1);
    chk("illegal_valid", {31'b0, imem_valid}, 32'h0);
    step(3);
    chk("illegal_pc_frozen", imem_addr, 32'h04);
    chk("illegal_sticky", {31'b0, exception}, 32'h1);
    rst = 1'b1;
    step(1);
    chk("rst_clears_exc", {31'b0, exception}, 32'h0);
    chk("rst_clears_pc", imem_addr, 32'h0);

    // Misaligned halfword store must not write
    clear_imem();
    imem[0] = enc_i(12'h101, 5'd0, 3'b000, 5'd5, 7'h13);         // addi x5,x0,257
    imem[1] = enc_s(12'd0, 5'd1, 5'd5, 3'b001);                  // sh x1,0(x5)
    do_reset();
    step(1);
    chk("mis_sh_no_we", {27'b0, mem_we, mem_w_mask}, 32'h0);
    step(1);
    chk("mis_sh_exc", {31'b0, exception}, 32'h1);
    chk("mis_sh_pc", imem_addr, 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_core.md
RISCV_CORE -- requirements
Module: riscv_core

Interface
REQ-001 Parameters: none; data/address width SHALL be rvcpu::Width = 32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 irq  in  1  wake-up request for WFI, level-sensitive.
REQ-005 imem_addr  out  32  byte address of instruction fetch, equals PC.
REQ-006 imem_data  in  32  instruction word, combinationally valid for imem_addr in the same cycle.
REQ-007 imem_valid  out  1  fetch request; high when not in reset and not halted by exception.
REQ-008 mem_addr  out  32  data byte address, word-aligned: {ea[31:2],2'b00}.
REQ-009 mem_w_data  out  32  store data, placed on its byte lanes.
REQ-010 mem_r_data  in  32  load data, combinationally valid in the same cycle as mem_re.
REQ-011 mem_w_mask  out  4  store byte-lane enables, bit i = byte i.
REQ-012 mem_re / mem_we  out  1 each  load / store strobe for the current cycle.
REQ-013 exception  out  1  sticky fault flag.
REQ-014 wfi  out  1  core is waiting in a WFI instruction.

Function
REQ-015 Single-cycle RV32I: one instruction fetched, executed and retired per clock, except when stalled by WFI or halted by exception.
REQ-016 Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP ALU ops; FENCE executes as NOP.
REQ-017 x0 SHALL read 0 and ignore writes; 31 general registers, 2 combinational read ports, 1 write port written at the clock edge.
REQ-018 Next PC: PC+4 by default; JAL/branch target PC+imm; JALR target (rs1+imm) with bit 0 cleared; rd receives PC+4.
REQ-019 Shifts use the low 5 bits of the operand; SLT/SLTU signed/unsigned compare; arithmetic wraps modulo 2^32.
REQ-020 Stores: mem_we=1; SB mask = 1<<ea[1:0], data = rs2[7:0] replicated on all lanes; SH mask = 4'b0011 or 4'b1100 by ea[1], data = rs2[15:0] replicated; SW mask = 4'b1111.
REQ-021 Loads: mem_re=1; byte/halfword selected by ea[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU), written to rd at the same edge.
REQ-022 mem_re, mem_we and mem_w_mask SHALL be 0 for all non-memory instructions.
REQ-023 Exception causes: undefined opcode/funct, ECALL, EBREAK, misaligned LH/LHU/SH (ea[0]=1), misaligned LW/SW (ea[1:0]!=0), taken jump/branch target with bit 1 set.
REQ-024 A faulting instruction SHALL NOT write a register or memory (mem_we=0); exception goes high at the next edge and stays high, PC frozen and imem_valid low, until reset.
REQ-025 WFI (0x10500073): wfi = 1 combinationally while WFI is the current instruction and irq=0; PC holds.
REQ-026 WFI with irq=1 in the same cycle SHALL retire as a NOP (PC+4, wfi=0).
REQ-027 No trap vectors or CSRs; irq has no effect outside WFI.

Reset
REQ-028 While rst=1: PC <= 0x0000_0000, exception <= 0, all registers x1..x31 <= 0, mem_we=0, mem_re=0, imem_valid=0, wfi=0.
REQ-029 First fetch from address 0 SHALL occur in the first cycle after rst deasserts.
REQ-030 rst asserted during a WFI stall or after an exception SHALL return the core to the REQ-028 state at the next edge.

Structure
REQ-031 Package rvcpu holds Width, addr_t, data_t, opcode enum, ALU-op enum, and load/store size enums.
REQ-032 One sub-module: regfile (2R/1W, x0 hardwired to 0); decode, immediate generation, ALU and load/store alignment stay inside riscv_core.

Verification
REQ-033 addi x1,x0,5; addi x2,x1,-3; add x3,x1,x2 -> x2=2, x3=7, PC=0x0C after 3 cycles.
REQ-034 x1=0xDEADBEEF, x5=0x100; sw x1,0(x5) -> mem_we=1, mask=1111, mem_addr=0x100; then lb x2,1(x5) -> x2=0xFFFFFFBE; lbu x3,1(x5) -> x3=0x000000BE.
REQ-035 sb x1,2(x5) -> mask=0100, mem_w_data[23:16]=0xEF; sh x1,2(x5) -> mask=1100, mem_w_data[31:16]=0xBEEF.
REQ-036 beq x0,x0,-8 at PC 0x10 -> next PC 0x08; bne x0,x0,-8 -> next PC 0x14; jal x1,+16 at 0x20 -> PC 0x30, x1=0x24.
REQ-037 WFI at PC 0x10 with irq=0 -> wfi=1, PC holds 0x10 for 5 cycles; irq=1 -> wfi=0, next PC 0x14.
REQ-038 Instruction 0x00000000 at PC 0x04 -> no register write, exception=1 from the next edge, PC stays 0x04, imem_valid=0 until rst.
